spi_regfile_peripheral: RTL and testbench



---
 rtl/spi_regfile_pkg.sv | 23 ++
 rtl/spi_regfile_peripheral_if.sv | 11 +
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_regfile_peripheral.sv | 213 +++++++++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared types and header layout for the SPI register-file peripheral.
// Header is shifted in MSB first: R/W bit on top, start address below it.
package spi_regfile_pkg;

  localparam logic RW_WRITE     = 1'b1;
  localparam int   HDR_ADDR_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_e;

  function automatic int hdr_len(input int addr_w);
    return 1 + addr_w;
  endfunction

  // R/W is the first header bit, so after shifting it sits above the address.
  function automatic int hdr_rw_pos(input int addr_w);
    return addr_w;
  endfunction

endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle between a controller (master) and the register-file peripheral (slave).
interface spi_regfile_peripheral_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output ncs, output copi, input cipo, input cipo_oe);
  modport slave  (input sclk, input ncs, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one async input plus a single-flop edge detector.
// Level, rise and fall are all in the core clock domain.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_lvl  = r_sync[SYNC_STAGES-1];
  assign o_rise = o_lvl & ~r_prev;
  assign o_fall = ~o_lvl & r_prev;
endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register file: header (R/W + start address) then auto-increment data words.
// Writes commit one clk after the word completes; reads stream reg contents MSB first on cipo.
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_regfile_peripheral_if.slave      spi,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);
  localparam int HDR_LEN = hdr_len(ADDR_W);
  localparam int RW_POS  = hdr_rw_pos(ADDR_W);
  localparam int HCW     = $clog2(HDR_LEN + 1);
  localparam int BCW     = $clog2(DATA_W + 1);
  localparam int WCW     = 8;
  localparam logic [HCW-1:0]  HDR_LAST   = HCW'(HDR_LEN - 1);
  localparam logic [BCW-1:0]  BIT_LAST   = BCW'(DATA_W - 1);
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic w_sclk_lvl_unused, w_sclk_rise, w_sclk_fall;
  logic w_ncs_lvl, w_ncs_rise, w_ncs_fall;
  logic w_copi, w_copi_rise_unused, w_copi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_d(spi.sclk),
    .o_lvl(w_sclk_lvl_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .i_d(spi.ncs),
    .o_lvl(w_ncs_lvl), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .i_d(spi.copi),
    .o_lvl(w_copi), .o_rise(w_copi_rise_unused), .o_fall(w_copi_fall_unused)
  );

  state_e                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_settle;
  logic                   r_armed;
  logic [HCW-1:0]         r_hdr_cnt;
  logic [BCW-1:0]         r_bit_cnt;
  logic [WCW-1:0]         r_word_cnt;
  logic [HDR_LEN-2:0]     r_hdr;
  logic [DATA_W-2:0]      r_rx;
  logic [DATA_W-1:0]      r_tx;
  logic                   r_rw;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_commit_vld;
  logic [ADDR_W-1:0]      r_commit_addr;
  logic [DATA_W-1:0]      r_commit_dat;
  logic                   r_frame_err;
  logic [DATA_W-1:0]      r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]    r_wr_strobe;

  logic                   w_frame_start, w_hdr_done, w_word_done, w_addr_ok;
  logic [HDR_LEN-1:0]     w_hdr_full;
  logic [DATA_W-1:0]      w_rx_full;
  logic [ADDR_W-1:0]      w_ld_addr;
  logic [DATA_W-1:0]      w_ld_dat;

  // A frame already running at reset release must not be picked up mid-way:
  // only arm once the flushed synchroniser has seen ncs high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_settle <= {r_settle[SYNC_STAGES-2:0], 1'b1};
      if (r_settle[SYNC_STAGES-1] && w_ncs_lvl) r_armed <= 1'b1;
    end
  end

  assign w_frame_start = w_ncs_fall & r_armed;
  assign w_hdr_full    = {r_hdr, w_copi};
  assign w_rx_full     = {r_rx, w_copi};
  assign w_addr_ok     = ({1'b0, r_addr} < NUM_REGS_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hdr_done  = 1'b0;
    w_word_done = 1'b0;
    case (r_state)
      ST_IDLE: if (w_frame_start) w_state_nxt = ST_HEADER;
      ST_HEADER: begin
        w_hdr_done = w_sclk_rise && (r_hdr_cnt == HDR_LAST);
        if (w_ncs_rise)      w_state_nxt = ST_IDLE;
        else if (w_hdr_done) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_word_done = w_sclk_rise && (r_bit_cnt == BIT_LAST);
        if (w_ncs_rise) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // First read word comes from the header address, later ones from the next address.
  always_comb begin
    w_ld_addr = (r_state == ST_HEADER) ? w_hdr_full[HDR_ADDR_LSB +: ADDR_W] : r_addr + 1'b1;
    w_ld_dat  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ld_addr == ADDR_W'(i)) w_ld_dat = r_regs[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_word_cnt    <= '0;
      r_hdr         <= '0;
      r_rx          <= '0;
      r_tx          <= '0;
      r_rw          <= 1'b0;
      r_addr        <= '0;
      r_commit_vld  <= 1'b0;
      r_commit_addr <= '0;
      r_commit_dat  <= '0;
      r_frame_err   <= 1'b0;
    end else begin
      r_commit_vld <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_frame_start) begin
        r_hdr_cnt  <= '0;
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
        r_hdr      <= '0;
        r_rx       <= '0;
        r_tx       <= '0;
      end
      if (r_state == ST_HEADER && w_sclk_rise) begin
        r_hdr     <= w_hdr_full[HDR_LEN-2:0];
        r_hdr_cnt <= r_hdr_cnt + 1'b1;
        if (w_hdr_done) begin
          r_rw   <= w_hdr_full[RW_POS];
          r_addr <= w_hdr_full[HDR_ADDR_LSB +: ADDR_W];
          r_tx   <= (w_hdr_full[RW_POS] == RW_WRITE) ? '0 : w_ld_dat;
        end
      end
      if (r_state == ST_DATA) begin
        if (w_sclk_rise) begin
          if (r_rw == RW_WRITE) r_rx <= w_rx_full[DATA_W-2:0];
          if (w_word_done) begin
            r_bit_cnt <= '0;
            r_addr    <= r_addr + 1'b1;
            if (r_word_cnt != '1) r_word_cnt <= r_word_cnt + 1'b1;
            if (r_rw == RW_WRITE) begin
              r_commit_vld  <= w_addr_ok;
              r_commit_addr <= r_addr;
              r_commit_dat  <= w_rx_full;
            end else begin
              r_tx <= w_ld_dat;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end else if (w_sclk_fall && r_rw != RW_WRITE && r_bit_cnt != '0) begin
          r_tx <= {r_tx[DATA_W-2:0], 1'b0};
        end
      end
      // Placed last so ncs rise wins the counters, while a same-clk commit still lands.
      if (w_ncs_rise) begin
        r_frame_err <= (r_state == ST_HEADER) ||
                       (r_state == ST_DATA && !w_word_done &&
                        (r_bit_cnt != '0 || r_word_cnt == '0));
        r_hdr_cnt  <= '0;
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
        r_hdr      <= '0;
        r_rx       <= '0;
        r_tx       <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wr_strobe <= '0;
    end else begin
      r_wr_strobe <= '0;
      if (r_commit_vld) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (r_commit_addr == ADDR_W'(i)) begin
            r_regs[i]      <= r_commit_dat;
            r_wr_strobe[i] <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_out[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign wr_strobe   = r_wr_strobe;
  assign frame_err   = r_frame_err;
  assign spi.cipo    = ~w_ncs_lvl & r_tx[DATA_W-1];
  assign spi.cipo_oe = ~w_ncs_lvl;
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench: frame-level register model plus a per-clk monitor on strobes, errors and cipo.
module tb_spi_regfile_peripheral;
  localparam int NR = 8;
  localparam int AW = 7;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [NR*DW-1:0] regs_out;
  logic [NR-1:0]    wr_strobe;
  logic             frame_err;

  int total = 0;
  int bad   = 0;

  spi_regfile_peripheral_if spi ();

  spi_regfile_peripheral #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi(spi),
    .regs_out(regs_out), .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  logic [7:0]    m_regs [NR];
  int            m_strobe_cnt = 0;
  int            m_err_cnt    = 0;
  logic [NR-1:0] m_mask       = '0;
  int            seen_strobe_cnt = 0;
  int            seen_err_cnt    = 0;
  logic [NR-1:0] seen_mask       = '0;
  logic [7:0]    tx_words [4];
  logic          mon_en = 1'b0;
  logic [NR*DW-1:0] prev_regs;
  logic [NR-1:0]    prev_strobe;
  logic             prev_err;
  logic [63:0]      rd;
  logic [7:0]       hdr8;
  logic             got_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b, output logic got);
    spi.copi = b;
    tick(8);
    spi.sclk = 1'b1;
    got = spi.cipo;
    tick(8);
    spi.sclk = 1'b0;
  endtask

  task automatic check_model();
    for (int i = 0; i < NR; i++)
      check($sformatf("reg%0d", i), regs_out[i*DW +: DW], m_regs[i]);
    check("strobe_count", seen_strobe_cnt, m_strobe_cnt);
    check("strobe_mask", seen_mask, m_mask);
    check("err_count", seen_err_cnt, m_err_cnt);
  endtask

  task automatic frame(input logic rw, input logic [6:0] addr, input int nbits, output logic [63:0] rdat);
    logic [7:0]  hdr, w;
    logic        b, got;
    logic [63:0] exp_rd;
    int          nw, a;
    hdr = {rw, addr};
    rdat = '0;
    exp_rd = '0;
    spi.ncs = 1'b0;
    tick(8);
    for (int k = 0; k < nbits; k++) begin
      if (k < 8) b = hdr[7-k];
      else begin
        w = tx_words[(k-8)/8];
        b = w[7-((k-8)%8)];
      end
      send_bit(b, got);
      if (k >= 8) rdat = {rdat[62:0], got};
      if (k == 0) check("oe_in_frame", spi.cipo_oe, 64'd1);
    end
    spi.copi = 1'b0;
    tick(8);
    spi.ncs = 1'b1;
    tick(12);
    check("oe_after_frame", spi.cipo_oe, 64'd0);
    nw = (nbits >= 8) ? (nbits - 8) / 8 : 0;
    for (int i = 0; i < nw; i++) begin
      a = (addr + i) % 128;
      if (rw) begin
        if (a < NR) begin
          m_regs[a] = tx_words[i];
          m_strobe_cnt++;
          m_mask[a] = 1'b1;
        end
      end else begin
        exp_rd = {exp_rd[55:0], (a < NR) ? m_regs[a] : 8'h00};
      end
    end
    if (nbits < 8 || ((nbits - 8) % 8) != 0 || nw == 0) m_err_cnt++;
    if (!rw) check("read_data", rdat, exp_rd);
    check_model();
  endtask

  // Per-clk rules: registers move only with their strobe, pulses last one clk, cipo silent when not driven.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      for (int i = 0; i < NR; i++)
        if (regs_out[i*DW +: DW] !== prev_regs[i*DW +: DW])
          check($sformatf("reg%0d_change_has_strobe", i), wr_strobe[i], 64'd1);
      check("strobe_one_clk", wr_strobe & prev_strobe, 64'd0);
      check("err_one_clk", frame_err & prev_err, 64'd0);
      check("cipo_zero_when_off", spi.cipo & ~spi.cipo_oe, 64'd0);
      seen_strobe_cnt += $countones(wr_strobe);
      seen_mask       |= wr_strobe;
      seen_err_cnt    += int'(frame_err);
    end
    prev_regs   = regs_out;
    prev_strobe = wr_strobe;
    prev_err    = frame_err;
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    spi.sclk = 1'b0;
    spi.ncs  = 1'b1;
    spi.copi = 1'b0;
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    tick(3);
    check("rst_regs", regs_out, 64'd0);
    check("rst_strobe", wr_strobe, 64'd0);
    check("rst_err", frame_err, 64'd0);
    check("rst_cipo", spi.cipo, 64'd0);
    check("rst_oe", spi.cipo_oe, 64'd0);
    rst_n = 1'b1;
    tick(10);
    mon_en = 1'b1;

    tx_words[0] = 8'hA5;
    frame(1'b1, 7'd2, 16, rd);
    check("lit_reg2_A5", regs_out[23:16], 64'hA5);
    check("lit_mask_reg2", seen_mask, 64'h04);

    frame(1'b0, 7'd2, 16, rd);
    check("lit_read_A5", rd, 64'hA5);

    tx_words[0] = 8'h11; tx_words[1] = 8'h22; tx_words[2] = 8'h33;
    frame(1'b1, 7'd6, 32, rd);
    check("lit_reg6_11", regs_out[55:48], 64'h11);
    check("lit_reg7_22", regs_out[63:56], 64'h22);
    check("lit_strobes_3", seen_strobe_cnt, 64'd3);

    tx_words[0] = 8'hFF;
    frame(1'b1, 7'd1, 12, rd);
    check("lit_cut_reg1", regs_out[15:8], 64'h00);
    check("lit_cut_err", seen_err_cnt, 64'd1);

    frame(1'b1, 7'd4, 8, rd);
    frame(1'b1, 7'd4, 5, rd);
    check("lit_err_3", seen_err_cnt, 64'd3);

    tx_words[0] = 8'h5C;
    frame(1'b1, 7'd0, 16, rd);
    frame(1'b0, 7'h7F, 24, rd);
    check("lit_wrap_read", rd, 64'h005C);

    hdr8 = {1'b1, 7'd3};
    spi.ncs = 1'b0;
    tick(8);
    for (int k = 0; k < 10; k++) send_bit((k < 8) ? hdr8[7-k] : 1'b1, got_b);
    rst_n = 1'b0;
    #1;
    check("rst_mid_regs", regs_out, 64'd0);
    check("rst_mid_strobe", wr_strobe, 64'd0);
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    tick(3);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) send_bit(1'b1, got_b);
    spi.copi = 1'b0;
    tick(8);
    spi.ncs = 1'b1;
    tick(12);
    check_model();

    tx_words[0] = 8'h3C;
    frame(1'b1, 7'd1, 16, rd);
    check("lit_recover_reg1", regs_out[15:8], 64'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
